// File: rtl/ac97_cmd_init.sv
// Writes the fixed AC97 codec register table over the command slots once the codec reports ready.
// Optional AC97_VOL_TRACK_EN: entry 0 carries vol, and later vol changes are re-issued from DONE.
module ac97_cmd_init #(
  parameter int HOLD_FRAMES    = 2,
  parameter int TIMEOUT_FRAMES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        audio_ready,
  input  logic        codec_ready,
  input  logic        frame_sync,
  input  logic [4:0]  vol,
  output logic        cmd_valid,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        busy,
  output logic        init_done,
  output logic        init_err
);

`ifdef AC97_VOL_TRACK_EN
  typedef enum logic [2:0] {IDLE, WAIT_CODEC, ISSUE, DONE, ERROR, UPDATE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_CODEC, ISSUE, DONE, ERROR} state_t;
`endif

  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);
  localparam logic [7:0] TO   = 8'(TIMEOUT_FRAMES);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [7:0]  fcnt, fcnt_nxt;
  logic [3:0]  hcnt, hcnt_nxt;
  logic        valid_nxt;
  logic [6:0]  addr_nxt;
  logic [15:0] data_nxt;
  logic [15:0] vol_word;
  logic        hold_hit;

`ifdef AC97_VOL_TRACK_EN
  logic [4:0] last_vol, last_vol_nxt;
  assign vol_word = {3'b0, vol, 3'b0, vol};
`else
  logic unused_vol;
  assign unused_vol = ^vol;
  assign vol_word   = 16'h0000;
`endif

  // Entry 0 data is supplied by the caller so the volume-tracking build can substitute vol.
  function automatic logic [22:0] entry(input logic [1:0] i, input logic [15:0] d0);
    logic [22:0] r;
    case (i)
      2'd0:    r = {7'h02, d0};
      2'd1:    r = {7'h04, 16'h0000};
      2'd2:    r = {7'h18, 16'h0808};
      default: r = {7'h2C, 16'hBB80};
    endcase
    return r;
  endfunction

  assign hold_hit = (hcnt + 4'd1) == HOLD;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fcnt_nxt  = fcnt;
    hcnt_nxt  = hcnt;
    valid_nxt = cmd_valid;
    addr_nxt  = cmd_addr;
    data_nxt  = cmd_data;
`ifdef AC97_VOL_TRACK_EN
    last_vol_nxt = last_vol;
`endif
    if (state != IDLE && !audio_ready) begin
      // Abort does not wait for a frame boundary.
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      fcnt_nxt  = 8'd0;
      hcnt_nxt  = 4'd0;
      valid_nxt = 1'b0;
      addr_nxt  = 7'h00;
      data_nxt  = 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (audio_ready) begin
            state_nxt = WAIT_CODEC;
            fcnt_nxt  = 8'd0;
          end
        end
        WAIT_CODEC: begin
          if (frame_sync) begin
            if (codec_ready) begin
              state_nxt              = ISSUE;
              idx_nxt                = 2'd0;
              hcnt_nxt               = 4'd0;
              valid_nxt              = 1'b1;
              {addr_nxt, data_nxt}   = entry(2'd0, vol_word);
`ifdef AC97_VOL_TRACK_EN
              last_vol_nxt           = vol;
`endif
            end else if ((fcnt + 8'd1) == TO) begin
              state_nxt = ERROR;
            end else begin
              fcnt_nxt = fcnt + 8'd1;
            end
          end
        end
        ISSUE: begin
          if (frame_sync) begin
            if (hold_hit) begin
              hcnt_nxt = 4'd0;
              if (idx == 2'd3) begin
                state_nxt = DONE;
                valid_nxt = 1'b0;
              end else begin
                idx_nxt              = idx + 2'd1;
                {addr_nxt, data_nxt} = entry(idx + 2'd1, vol_word);
              end
            end else begin
              hcnt_nxt = hcnt + 4'd1;
            end
          end
        end
        DONE: begin
`ifdef AC97_VOL_TRACK_EN
          if (frame_sync && vol != last_vol) begin
            state_nxt    = UPDATE;
            hcnt_nxt     = 4'd0;
            valid_nxt    = 1'b1;
            addr_nxt     = 7'h02;
            data_nxt     = vol_word;
            last_vol_nxt = vol;
          end
`endif
        end
`ifdef AC97_VOL_TRACK_EN
        UPDATE: begin
          if (frame_sync) begin
            if (hold_hit) begin
              state_nxt = DONE;
              hcnt_nxt  = 4'd0;
              valid_nxt = 1'b0;
            end else begin
              hcnt_nxt = hcnt + 4'd1;
            end
          end
        end
`endif
        ERROR:   ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      fcnt      <= 8'd0;
      hcnt      <= 4'd0;
      cmd_valid <= 1'b0;
      cmd_addr  <= 7'h00;
      cmd_data  <= 16'h0000;
`ifdef AC97_VOL_TRACK_EN
      last_vol  <= 5'd0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      fcnt      <= fcnt_nxt;
      hcnt      <= hcnt_nxt;
      cmd_valid <= valid_nxt;
      cmd_addr  <= addr_nxt;
      cmd_data  <= data_nxt;
`ifdef AC97_VOL_TRACK_EN
      last_vol  <= last_vol_nxt;
`endif
    end
  end

`ifdef AC97_VOL_TRACK_EN
  assign busy      = (state == WAIT_CODEC) || (state == ISSUE) || (state == UPDATE);
  assign init_done = (state == DONE) || (state == UPDATE);
`else
  assign busy      = (state == WAIT_CODEC) || (state == ISSUE);
  assign init_done = (state == DONE);
`endif
  assign init_err  = (state == ERROR);

endmodule
